// File: rtl/sc_hex_scan_if.sv
// ---------------------------------------------------------------------------
// sc_hex_scan_if
// Bundle between the nibble source and the two-digit scanned display driver.
//   SC_HEXSCAN_data_InLow   [3:0]  low nibble, shown on digit 0
//   SC_HEXSCAN_data_InHigh  [3:0]  high nibble, shown on digit 1
//   SC_HEXSCAN_load_In             level, captures both nibbles into the shadow
//   SC_HEXSCAN_enable_In           1 scans the display, 0 blanks it
//   SC_HEXSCAN_suppress_In         1 blanks digit 1 when its nibble is zero
//   SC_HEXSCAN_segments_Out [6:0]  {g,f,e,d,c,b,a}
//   SC_HEXSCAN_digit_Out    [1:0]  digit selects, bit0 = digit 0
//   SC_HEXSCAN_ack_Out             one-cycle pulse on shadow -> display copy
// master drives the inputs of the display driver, slave is the driver itself.
// ---------------------------------------------------------------------------
interface sc_hex_scan_if;
   logic [3:0] SC_HEXSCAN_data_InLow;
   logic [3:0] SC_HEXSCAN_data_InHigh;
   logic       SC_HEXSCAN_load_In;
   logic       SC_HEXSCAN_enable_In;
   logic       SC_HEXSCAN_suppress_In;
   logic [6:0] SC_HEXSCAN_segments_Out;
   logic [1:0] SC_HEXSCAN_digit_Out;
   logic       SC_HEXSCAN_ack_Out;

   modport master (
      output SC_HEXSCAN_data_InLow, SC_HEXSCAN_data_InHigh, SC_HEXSCAN_load_In,
             SC_HEXSCAN_enable_In, SC_HEXSCAN_suppress_In,
      input  SC_HEXSCAN_segments_Out, SC_HEXSCAN_digit_Out, SC_HEXSCAN_ack_Out
   );

   modport slave (
      input  SC_HEXSCAN_data_InLow, SC_HEXSCAN_data_InHigh, SC_HEXSCAN_load_In,
             SC_HEXSCAN_enable_In, SC_HEXSCAN_suppress_In,
      output SC_HEXSCAN_segments_Out, SC_HEXSCAN_digit_Out, SC_HEXSCAN_ack_Out
   );
endinterface

// File: rtl/sc_hex_scan.sv
// ---------------------------------------------------------------------------
// sc_hex_scan
// Double-buffered two-digit multiplexed 7-segment driver. Loads land in a
// shadow register; the shadow is copied to the display register only at a
// frame boundary so a frame never shows a torn value. A prescaled scan FSM
// lights digit 0, blanks, lights digit 1, blanks, and repeats.
// Ports:
//   SC_HEXSCAN_CLOCK_50     system clock, rising edge
//   SC_HEXSCAN_RESET_InLow  asynchronous active-low reset
//   bus                     sc_hex_scan_if.slave (nibbles, load, enable,
//                           suppress in; segments, digits, ack out)
// ---------------------------------------------------------------------------
module sc_hex_scan #(
   parameter int DIGIT_TICKS  = 50000,
   parameter int GAP_TICKS    = 8,
   parameter int CNT_WIDTH    = 16,
   parameter int COMMON_ANODE = 1
) (
   input  logic         SC_HEXSCAN_CLOCK_50,
   input  logic         SC_HEXSCAN_RESET_InLow,
   sc_hex_scan_if.slave bus
);

   typedef enum logic [2:0] {
      S_OFF = 3'd0,
      S_D0  = 3'd1,
      S_G0  = 3'd2,
      S_D1  = 3'd3,
      S_G1  = 3'd4
   } state_t;

   localparam logic [CNT_WIDTH-1:0] DIGIT_LAST = CNT_WIDTH'(DIGIT_TICKS - 1);
   localparam logic [CNT_WIDTH-1:0] GAP_LAST   = CNT_WIDTH'(GAP_TICKS - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
   localparam logic                 ACTIVE_LOW = (COMMON_ANODE != 0);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [7:0]           shadow_q, shadow_d;
   logic [7:0]           display_q, display_d;
   logic                 pending_q, pending_d;
   logic                 ack_q, ack_d;
   logic                 boundary_s;
   logic [6:0]           seg_on_s;
   logic [1:0]           dig_on_s;

   // Active-high hex glyph, bits {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0:    hex7 = 7'h3F;
         4'h1:    hex7 = 7'h06;
         4'h2:    hex7 = 7'h5B;
         4'h3:    hex7 = 7'h4F;
         4'h4:    hex7 = 7'h66;
         4'h5:    hex7 = 7'h6D;
         4'h6:    hex7 = 7'h7D;
         4'h7:    hex7 = 7'h07;
         4'h8:    hex7 = 7'h7F;
         4'h9:    hex7 = 7'h6F;
         4'hA:    hex7 = 7'h77;
         4'hB:    hex7 = 7'h7C;
         4'hC:    hex7 = 7'h39;
         4'hD:    hex7 = 7'h5E;
         4'hE:    hex7 = 7'h79;
         4'hF:    hex7 = 7'h71;
         default: hex7 = 7'h00;
      endcase
   endfunction

   // Scan state register.
   always_ff @(posedge SC_HEXSCAN_CLOCK_50 or negedge SC_HEXSCAN_RESET_InLow) begin
      if (!SC_HEXSCAN_RESET_InLow) begin
         state_q <= S_OFF;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: dropping enable overrides everything; otherwise each
   // phase advances when its prescaler reaches its last tick.
   always_comb begin
      state_d = state_q;
      if (!bus.SC_HEXSCAN_enable_In) begin
         state_d = S_OFF;
      end else begin
         case (state_q)
            S_OFF:   state_d = S_D0;
            S_D0:    if (cnt_q == DIGIT_LAST) state_d = S_G0; else state_d = S_D0;
            S_G0:    if (cnt_q == GAP_LAST)   state_d = S_D1; else state_d = S_G0;
            S_D1:    if (cnt_q == DIGIT_LAST) state_d = S_G1; else state_d = S_D1;
            S_G1:    if (cnt_q == GAP_LAST)   state_d = S_D0; else state_d = S_G1;
            default: state_d = S_OFF;
         endcase
      end
   end

   // Prescaler, double buffer and transfer handshake next values.
   always_comb begin
      // S_OFF is a boundary on every cycle so a load while blanked is
      // picked up promptly; otherwise only the entry into S_D0 is.
      boundary_s = (state_q == S_OFF) || ((state_d == S_D0) && (state_q != S_D0));
      if ((state_d != state_q) || (state_q == S_OFF)) begin
         cnt_d = {CNT_WIDTH{1'b0}};
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
      ack_d = boundary_s && pending_q;
      // The transfer uses the pre-edge shadow; a same-cycle load is kept
      // pending for the following boundary.
      if (ack_d) begin
         display_d = shadow_q;
      end else begin
         display_d = display_q;
      end
      if (bus.SC_HEXSCAN_load_In) begin
         shadow_d  = {bus.SC_HEXSCAN_data_InHigh, bus.SC_HEXSCAN_data_InLow};
         pending_d = 1'b1;
      end else if (boundary_s) begin
         shadow_d  = shadow_q;
         pending_d = 1'b0;
      end else begin
         shadow_d  = shadow_q;
         pending_d = pending_q;
      end
   end

   // Prescaler and datapath registers.
   always_ff @(posedge SC_HEXSCAN_CLOCK_50 or negedge SC_HEXSCAN_RESET_InLow) begin
      if (!SC_HEXSCAN_RESET_InLow) begin
         cnt_q     <= {CNT_WIDTH{1'b0}};
         shadow_q  <= 8'h00;
         display_q <= 8'h00;
         pending_q <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         shadow_q  <= shadow_d;
         display_q <= display_d;
         pending_q <= pending_d;
         ack_q     <= ack_d;
      end
   end

   // Moore decode of state and display register, active-high internally.
   always_comb begin
      seg_on_s = 7'h00;
      dig_on_s = 2'b00;
      case (state_q)
         S_D0: begin
            dig_on_s = 2'b01;
            seg_on_s = hex7(display_q[3:0]);
         end
         S_D1: begin
            if (bus.SC_HEXSCAN_suppress_In && (display_q[7:4] == 4'h0)) begin
               dig_on_s = 2'b00;
               seg_on_s = 7'h00;
            end else begin
               dig_on_s = 2'b10;
               seg_on_s = hex7(display_q[7:4]);
            end
         end
         default: begin
            dig_on_s = 2'b00;
            seg_on_s = 7'h00;
         end
      endcase
   end

   assign bus.SC_HEXSCAN_segments_Out = seg_on_s ^ {7{ACTIVE_LOW}};
   assign bus.SC_HEXSCAN_digit_Out    = dig_on_s ^ {2{ACTIVE_LOW}};
   assign bus.SC_HEXSCAN_ack_Out      = ack_q;

endmodule

// File: tb/tb_sc_hex_scan.sv
// ---------------------------------------------------------------------------
// tb_sc_hex_scan
// Self-checking bench for sc_hex_scan with DIGIT_TICKS=4, GAP_TICKS=1,
// COMMON_ANODE=1. The reference model tracks time since the scan started
// and derives the phase from (time mod frame period).
// ---------------------------------------------------------------------------
module tb_sc_hex_scan;
   localparam int DT = 4;
   localparam int GT = 1;
   localparam int P  = 2 * (DT + GT);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sc_hex_scan_if bus ();

   sc_hex_scan #(
      .DIGIT_TICKS(DT), .GAP_TICKS(GT), .CNT_WIDTH(16), .COMMON_ANODE(1)
   ) dut (
      .SC_HEXSCAN_CLOCK_50(clk),
      .SC_HEXSCAN_RESET_InLow(rst_n),
      .bus(bus)
   );

   typedef struct {
      logic       en;
      logic       ld;
      logic [3:0] hi;
      logic [3:0] lo;
      logic [1:0] dig;
      logic [6:0] seg;
      logic       ack;
   } vec_t;

   vec_t       vecs [13];
   logic [6:0] hex_tab [16];
   int         n_chk = 0;
   int         n_fail = 0;

   // reference model state
   bit         m_on;
   int         m_t;
   logic [7:0] m_shadow, m_disp;
   bit         m_pend, m_ack;

   logic [1:0] obs_d;
   logic [6:0] obs_s;
   logic       obs_a;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_on = 1'b0; m_t = 0; m_shadow = 8'h00; m_disp = 8'h00; m_pend = 1'b0; m_ack = 1'b0;
   endtask

   task automatic model_expect(input logic sup, output logic [1:0] d, output logic [6:0] s);
      int p;
      logic [1:0] on_d;
      logic [6:0] on_s;
      on_d = 2'b00;
      on_s = 7'h00;
      if (m_on) begin
         p = m_t % P;
         if (p < DT) begin
            on_d = 2'b01;
            on_s = hex_tab[m_disp[3:0]];
         end else if (p >= DT + GT && p < 2 * DT + GT) begin
            if (!(sup && m_disp[7:4] == 4'h0)) begin
               on_d = 2'b10;
               on_s = hex_tab[m_disp[7:4]];
            end
         end
      end
      d = ~on_d;
      s = ~on_s;
   endtask

   task automatic model_step(input logic en, input logic ld, input logic [3:0] hi, input logic [3:0] lo);
      bit boundary;
      boundary = !m_on || (en && ((m_t % P) == P - 1));
      m_ack = boundary && m_pend;
      if (m_ack) m_disp = m_shadow;
      if (ld) begin
         m_shadow = {hi, lo};
         m_pend = 1'b1;
      end else if (boundary) begin
         m_pend = 1'b0;
      end
      if (!en) begin
         m_on = 1'b0; m_t = 0;
      end else if (!m_on) begin
         m_on = 1'b1; m_t = 0;
      end else begin
         m_t++;
      end
   endtask

   // one clock cycle: drive, sample and compare mid-cycle, then clock the model
   task automatic cycle(input logic en, input logic ld, input logic [3:0] hi, input logic [3:0] lo, input logic sup);
      logic [1:0] ed;
      logic [6:0] es;
      @(negedge clk);
      bus.SC_HEXSCAN_enable_In   = en;
      bus.SC_HEXSCAN_load_In     = ld;
      bus.SC_HEXSCAN_data_InHigh = hi;
      bus.SC_HEXSCAN_data_InLow  = lo;
      bus.SC_HEXSCAN_suppress_In = sup;
      #1;
      model_expect(sup, ed, es);
      obs_d = bus.SC_HEXSCAN_digit_Out;
      obs_s = bus.SC_HEXSCAN_segments_Out;
      obs_a = bus.SC_HEXSCAN_ack_Out;
      check("model_digit", 32'(obs_d), 32'(ed));
      check("model_seg", 32'(obs_s), 32'(es));
      check("model_ack", 32'(obs_a), 32'(m_ack));
      @(posedge clk);
      model_step(en, ld, hi, lo);
   endtask

   task automatic idle_inputs();
      bus.SC_HEXSCAN_enable_In   = 1'b0;
      bus.SC_HEXSCAN_load_In     = 1'b0;
      bus.SC_HEXSCAN_data_InHigh = 4'h0;
      bus.SC_HEXSCAN_data_InLow  = 4'h0;
      bus.SC_HEXSCAN_suppress_In = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      #1;
      model_reset();
      check("rst_digit", 32'(bus.SC_HEXSCAN_digit_Out), 32'(2'b11));
      check("rst_seg", 32'(bus.SC_HEXSCAN_segments_Out), 32'(7'h7F));
      check("rst_ack", 32'(bus.SC_HEXSCAN_ack_Out), 32'(1'b0));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int acks;
      logic sup_r;
      idle_inputs();
      hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      // load {3,A} while blanked, then scan one full frame
      vecs[0]  = '{1'b0, 1'b1, 4'h3, 4'hA, 2'b11, 7'h7F, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 4'h0, 4'h0, 2'b11, 7'h7F, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 4'h0, 4'h0, 2'b10, 7'h08, 1'b1};
      vecs[3]  = '{1'b1, 1'b0, 4'h0, 4'h0, 2'b10, 7'h08, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 4'h0, 4'h0, 2'b10, 7'h08, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 4'h0, 4'h0, 2'b10, 7'h08, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 4'h0, 4'h0, 2'b11, 7'h7F, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 4'h0, 4'h0, 2'b01, 7'h30, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 4'h0, 4'h0, 2'b01, 7'h30, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 4'h0, 4'h0, 2'b01, 7'h30, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 4'h0, 4'h0, 2'b01, 7'h30, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 4'h0, 4'h0, 2'b11, 7'h7F, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 4'h0, 4'h0, 2'b10, 7'h08, 1'b0};

      do_reset();
      for (int i = 0; i < 13; i++) begin
         cycle(vecs[i].en, vecs[i].ld, vecs[i].hi, vecs[i].lo, 1'b0);
         check("vec_digit", 32'(obs_d), 32'(vecs[i].dig));
         check("vec_seg", 32'(obs_s), 32'(vecs[i].seg));
         check("vec_ack", 32'(obs_a), 32'(vecs[i].ack));
      end

      // mid-frame load during S_D1 must not tear the current frame
      do_reset();
      cycle(1'b0, 1'b1, 4'h1, 4'h2, 1'b0);
      cycle(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      acks = 0;
      for (int k = 0; k < 30; k++) begin
         cycle(1'b1, (k == 6), 4'h7, 4'h5, 1'b0);
         if (k >= 5 && k <= 8) begin
            check("dbuf_d1_digit", 32'(obs_d), 32'(2'b01));
            check("dbuf_d1_seg", 32'(obs_s), 32'(7'h79));
         end
         if (k == 10) begin
            check("dbuf_new_seg", 32'(obs_s), 32'(7'h12));
            check("dbuf_new_ack", 32'(obs_a), 32'(1'b1));
         end
         if (k >= 6 && obs_a === 1'b1) acks++;
      end
      check("dbuf_ack_count", 32'(acks), 32'(1));

      // load on the exact S_G1 -> S_D0 edge with an earlier load pending
      do_reset();
      cycle(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      acks = 0;
      for (int k = 0; k < 30; k++) begin
         cycle(1'b1, (k == 2) || (k == 9), (k == 2) ? 4'h4 : 4'h9, (k == 2) ? 4'h4 : 4'h9, 1'b0);
         if (k == 10) begin
            check("edge_first_seg", 32'(obs_s), 32'(7'h19));
            check("edge_first_ack", 32'(obs_a), 32'(1'b1));
         end
         if (k == 15) check("edge_first_hi", 32'(obs_s), 32'(7'h19));
         if (k == 20) begin
            check("edge_second_seg", 32'(obs_s), 32'(7'h10));
            check("edge_second_ack", 32'(obs_a), 32'(1'b1));
         end
         if (k >= 10 && obs_a === 1'b1) acks++;
      end
      check("edge_ack_count", 32'(acks), 32'(2));

      // leading-zero suppression of digit 1
      do_reset();
      cycle(1'b0, 1'b1, 4'h0, 4'h8, 1'b0);
      cycle(1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
      for (int k = 0; k < 20; k++) begin
         cycle(1'b1, 1'b0, 4'h0, 4'h0, (k < 10));
         if (k == 0) check("sup_d0_seg", 32'(obs_s), 32'(7'h00));
         if (k == 5) begin
            check("sup_d1_digit", 32'(obs_d), 32'(2'b11));
            check("sup_d1_seg", 32'(obs_s), 32'(7'h7F));
         end
         if (k == 15) begin
            check("nosup_d1_digit", 32'(obs_d), 32'(2'b01));
            check("nosup_d1_seg", 32'(obs_s), 32'(7'h40));
         end
      end

      // enable dropped mid-S_D1, load while blanked, re-enable
      do_reset();
      cycle(1'b0, 1'b1, 4'h1, 4'h2, 1'b0);
      cycle(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      for (int k = 0; k < 18; k++) begin
         cycle((k < 7) || (k >= 10), (k == 8), 4'h5, 4'h6, 1'b0);
         if (k == 8) check("off_digit", 32'(obs_d), 32'(2'b11));
         if (k == 10) check("off_ack", 32'(obs_a), 32'(1'b1));
         if (k >= 11 && k <= 14) begin
            check("reen_digit", 32'(obs_d), 32'(2'b10));
            check("reen_seg", 32'(obs_s), 32'(7'h02));
         end
         if (k == 15) check("reen_gap", 32'(obs_d), 32'(2'b11));
      end

      // asynchronous reset in the middle of an S_D0 cycle
      do_reset();
      cycle(1'b0, 1'b1, 4'h1, 4'h9, 1'b0);
      cycle(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      cycle(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      check("pre_arst_seg", 32'(obs_s), 32'(7'h10));
      @(negedge clk);
      #2;
      idle_inputs();
      rst_n = 1'b0;
      #1;
      check("arst_digit", 32'(bus.SC_HEXSCAN_digit_Out), 32'(2'b11));
      check("arst_seg", 32'(bus.SC_HEXSCAN_segments_Out), 32'(7'h7F));
      check("arst_ack", 32'(bus.SC_HEXSCAN_ack_Out), 32'(1'b0));
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      for (int k = 0; k < 12; k++) begin
         cycle(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
         if (k == 0) begin
            check("post_arst_digit", 32'(obs_d), 32'(2'b10));
            check("post_arst_seg", 32'(obs_s), 32'(7'h40));
         end
         check("post_arst_ack", 32'(obs_a), 32'(1'b0));
      end

      // randomized traffic against the model
      do_reset();
      sup_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 15) != 0), ($urandom_range(0, 7) == 0),
               4'($urandom), 4'($urandom), sup_r);
         if ($urandom_range(0, 31) == 0) sup_r = ~sup_r;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
